// File: rtl/shift_unit_pipe.sv
// shift_unit_pipe: pipelined barrel shifter/rotator with word mode, valid/ready flow control and tag passthrough
module shift_unit_pipe #(
    parameter int WIDTH  = 32,
    parameter int STAGES = 2,
    parameter int TAG_W  = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic [2:0]       in_op,
    input  logic             in_word,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_result,
    output logic [TAG_W-1:0] out_tag,
    output logic             out_illegal
);
    localparam int SHW = $clog2(WIDTH);
    localparam logic [2:0] OP_SLL = 3'd0;
    localparam logic [2:0] OP_SRL = 3'd1;
    localparam logic [2:0] OP_SRA = 3'd2;
    localparam logic [2:0] OP_ROL = 3'd3;
    localparam logic [2:0] OP_ROR = 3'd4;

    // One barrel level: shift/rotate by s, either full width or within the low word
    function automatic logic [WIDTH-1:0] lvl(input logic [WIDTH-1:0] x, input logic [2:0] op,
                                             input logic w, input int s);
        logic [31:0]      l;
        logic [31:0]      sra_l;
        logic [31:0]      r32;
        logic [WIDTH-1:0] sra_x;
        logic [WIDTH-1:0] r;
        l     = x[31:0];
        sra_l = $signed(l) >>> s;
        sra_x = $signed(x) >>> s;
        r32 = op == OP_SLL ? l << s :
              op == OP_SRL ? l >> s :
              op == OP_SRA ? sra_l :
              op == OP_ROL ? (l << s) | (l >> (32 - s)) :
              op == OP_ROR ? (l >> s) | (l << (32 - s)) : l;
        r   = op == OP_SLL ? x << s :
              op == OP_SRL ? x >> s :
              op == OP_SRA ? sra_x :
              op == OP_ROL ? (x << s) | (x >> (WIDTH - s)) :
              op == OP_ROR ? (x >> s) | (x << (WIDTH - s)) : x;
        return w ? WIDTH'(r32) : r;
    endfunction

    logic             en;
    logic             word_in;
    logic [SHW-1:0]   amt_in;
    logic             unused_b;

    logic             pv [STAGES];
    logic [WIDTH-1:0] pd [STAGES];
    logic [SHW-1:0]   pa [STAGES];
    logic [2:0]       po [STAGES];
    logic             pw [STAGES];
    logic [TAG_W-1:0] pt [STAGES];
    logic [WIDTH-1:0] nx [STAGES];

    logic             vr  [STAGES];
    logic [WIDTH-1:0] dr  [STAGES];
    logic [SHW-1:0]   ar  [STAGES];
    logic [2:0]       opr [STAGES];
    logic             wr  [STAGES];
    logic [TAG_W-1:0] tr  [STAGES];

    assign word_in     = (WIDTH == 64) && in_word;
    assign amt_in      = word_in ? SHW'(in_b[4:0]) : in_b[SHW-1:0];
    assign unused_b    = ^in_b[WIDTH-1:SHW];
    assign en          = !out_valid || out_ready;
    assign in_ready    = en && !reset;
    assign out_valid   = vr[STAGES-1];
    assign out_result  = dr[STAGES-1];
    assign out_tag     = tr[STAGES-1];
    assign out_illegal = opr[STAGES-1] > OP_ROR;

    // Stage inputs: stage 0 sees the issue port, later stages see the previous register
    always_comb begin
        pv[0] = in_valid;
        pd[0] = in_a;
        pa[0] = amt_in;
        po[0] = in_op;
        pw[0] = word_in;
        pt[0] = in_tag;
        for (int g = 1; g < STAGES; g++) begin
            pv[g] = vr[g-1];
            pd[g] = dr[g-1];
            pa[g] = ar[g-1];
            po[g] = opr[g-1];
            pw[g] = wr[g-1];
            pt[g] = tr[g-1];
        end
    end

    // Each stage applies its share of levels; the last stage also sign-extends words and zeroes reserved ops
    always_comb begin
        for (int g = 0; g < STAGES; g++) begin
            logic [WIDTH-1:0]  x;
            logic signed [31:0] lo;
            logic [WIDTH-1:0]  sx;
            x = pd[g];
            for (int k = 0; k < SHW; k++)
                if ((k * STAGES) / SHW == g && pa[g][k]) x = lvl(x, po[g], pw[g], 1 << k);
            lo = x[31:0];
            sx = WIDTH'(lo);
            if (g == STAGES - 1) x = po[g] > OP_ROR ? '0 : pw[g] ? sx : x;
            nx[g] = x;
        end
    end

    // Pipeline registers: all stages advance together on en; payload loads only behind a valid bit
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int g = 0; g < STAGES; g++) begin
                vr[g]  <= 1'b0;
                dr[g]  <= '0;
                ar[g]  <= '0;
                opr[g] <= '0;
                wr[g]  <= 1'b0;
                tr[g]  <= '0;
            end
        end else if (en) begin
            for (int g = 0; g < STAGES; g++) begin
                vr[g] <= pv[g];
                if (pv[g]) begin
                    dr[g]  <= nx[g];
                    ar[g]  <= pa[g];
                    opr[g] <= po[g];
                    wr[g]  <= pw[g];
                    tr[g]  <= pt[g];
                end
            end
        end
    end
endmodule

// File: tb/tb_shift_unit_pipe.sv
// tb_shift_unit_pipe: scoreboard bench for a 32-bit/2-stage and a 64-bit/3-stage shifter
module tb_shift_unit_pipe;
    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic reset;

    logic        a_in_valid, a_in_ready, a_in_word, a_out_valid, a_out_ready, a_out_illegal;
    logic [31:0] a_in_a, a_in_b, a_out_result;
    logic [2:0]  a_in_op;
    logic [3:0]  a_in_tag, a_out_tag;

    logic        b_in_valid, b_in_ready, b_in_word, b_out_valid, b_out_ready, b_out_illegal;
    logic [63:0] b_in_a, b_in_b, b_out_result;
    logic [2:0]  b_in_op;
    logic [3:0]  b_in_tag, b_out_tag;

    shift_unit_pipe #(.WIDTH(32), .STAGES(2), .TAG_W(4)) dut_a (
        .clk(clk), .reset(reset), .in_valid(a_in_valid), .in_ready(a_in_ready),
        .in_a(a_in_a), .in_b(a_in_b), .in_op(a_in_op), .in_word(a_in_word), .in_tag(a_in_tag),
        .out_valid(a_out_valid), .out_ready(a_out_ready), .out_result(a_out_result),
        .out_tag(a_out_tag), .out_illegal(a_out_illegal));

    shift_unit_pipe #(.WIDTH(64), .STAGES(3), .TAG_W(4)) dut_b (
        .clk(clk), .reset(reset), .in_valid(b_in_valid), .in_ready(b_in_ready),
        .in_a(b_in_a), .in_b(b_in_b), .in_op(b_in_op), .in_word(b_in_word), .in_tag(b_in_tag),
        .out_valid(b_out_valid), .out_ready(b_out_ready), .out_result(b_out_result),
        .out_tag(b_out_tag), .out_illegal(b_out_illegal));

    typedef struct {
        logic [63:0] res;
        logic [3:0]  tag;
        logic        ill;
    } exp_t;

    exp_t qa[$];
    exp_t qb[$];
    int tests = 0;
    int fails = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got %h, expected %h", name, act, req);
        end
    endtask

    // Drive one op on unit a (sel=0) or b (sel=1); expectation is queued once acceptance is certain
    task automatic send(input bit sel, input logic [2:0] op, input logic [63:0] a, input logic [63:0] b,
                        input logic w, input logic [3:0] tag, input logic [63:0] res);
        int n = 0;
        if (sel) begin
            b_in_op = op; b_in_a = a; b_in_b = b; b_in_word = w; b_in_tag = tag; b_in_valid = 1'b1;
        end else begin
            a_in_op = op; a_in_a = a[31:0]; a_in_b = b[31:0]; a_in_word = w; a_in_tag = tag; a_in_valid = 1'b1;
        end
        @(negedge clk);
        while (!(sel ? b_in_ready : a_in_ready) && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (n >= 50) begin
            tests++;
            fails++;
            $display("FAIL send_timeout unit %0d tag %0d: in_ready got 0, expected 1", sel, tag);
        end else if (sel) qb.push_back('{res, tag, op > 3'd4});
        else qa.push_back('{res, tag, op > 3'd4});
        @(posedge clk);
        #1;
        if (sel) b_in_valid = 1'b0;
        else a_in_valid = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while ((qa.size() != 0 || qb.size() != 0) && n < 200) begin
            @(negedge clk);
            n++;
        end
        repeat (4) @(negedge clk);
        chk("a_queue_empty", 64'(qa.size()), 0);
        chk("b_queue_empty", 64'(qb.size()), 0);
        @(posedge clk);
        #1;
    endtask

    // Monitor for unit a: scoreboard pops, stall stability and in_ready during stall
    initial begin
        exp_t e;
        logic a_prev;
        logic [36:0] a_hold;
        a_prev = 1'b0;
        a_hold = '0;
        forever begin
            @(negedge clk);
            if (reset) a_prev = 1'b0;
            else begin
                if (a_prev) chk("a_stall_hold", {a_out_illegal, a_out_tag, a_out_result}, a_hold);
                if (a_out_valid && !a_out_ready) chk("a_stall_in_ready", a_in_ready, 0);
                if (a_out_valid && a_out_ready) begin
                    if (qa.size() == 0) begin
                        tests++;
                        fails++;
                        $display("FAIL a_unexpected_output: got tag %0d, expected no output", a_out_tag);
                    end else begin
                        e = qa.pop_front();
                        chk("a_result", a_out_result, e.res[31:0]);
                        chk("a_tag", a_out_tag, e.tag);
                        chk("a_illegal", a_out_illegal, e.ill);
                    end
                end
                a_prev = a_out_valid && !a_out_ready;
                a_hold = {a_out_illegal, a_out_tag, a_out_result};
            end
        end
    end

    // Monitor for unit b
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (!reset && b_out_valid && b_out_ready) begin
                if (qb.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL b_unexpected_output: got tag %0d, expected no output", b_out_tag);
                end else begin
                    e = qb.pop_front();
                    chk("b_result", b_out_result, e.res);
                    chk("b_tag", b_out_tag, e.tag);
                    chk("b_illegal", b_out_illegal, e.ill);
                end
            end
        end
    end

    initial begin
        reset = 1'b1;
        a_in_valid = 0; a_in_a = 0; a_in_b = 0; a_in_op = 0; a_in_word = 0; a_in_tag = 0; a_out_ready = 1;
        b_in_valid = 0; b_in_a = 0; b_in_b = 0; b_in_op = 0; b_in_word = 0; b_in_tag = 0; b_out_ready = 1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_a_out_valid", a_out_valid, 0);
        chk("rst_a_out_result", a_out_result, 0);
        chk("rst_a_out_tag", a_out_tag, 0);
        chk("rst_a_out_illegal", a_out_illegal, 0);
        chk("rst_a_in_ready", a_in_ready, 0);
        chk("rst_b_out_valid", b_out_valid, 0);
        chk("rst_b_out_result", b_out_result, 0);
        @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        chk("a_in_ready_after_reset", a_in_ready, 1);
        chk("b_in_ready_after_reset", b_in_ready, 1);
        @(posedge clk);
        #1;

        send(0, 3'd2, 64'h8000_0010, 4, 0, 4'h3, 64'hF800_0001);
        @(negedge clk);
        chk("a_latency_cycle1", a_out_valid, 0);
        @(negedge clk);
        chk("a_latency_cycle2", a_out_valid, 1);
        @(posedge clk);
        #1;
        send(0, 3'd4, 64'h0000_00F1, 4, 0, 4'h1, 64'h1000_000F);
        send(0, 3'd3, 64'h8000_0001, 64'h21, 0, 4'h2, 64'h0000_0003);
        send(0, 3'd0, 64'h1234_5678, 0, 0, 4'h4, 64'h1234_5678);
        send(0, 3'd0, 64'h1, 31, 0, 4'h7, 64'h8000_0000);
        send(0, 3'd1, 64'h8000_0000, 31, 0, 4'h8, 64'h1);
        send(0, 3'd2, 64'h8000_0000, 1, 1, 4'h9, 64'hC000_0000);

        send(1, 3'd1, 64'hFFFF_FFFF_8000_0000, 1, 1, 4'h1, 64'h0000_0000_4000_0000);
        send(1, 3'd0, 64'h1, 31, 1, 4'h2, 64'hFFFF_FFFF_8000_0000);
        send(1, 3'd0, 64'h1, 63, 0, 4'h3, 64'h8000_0000_0000_0000);
        send(1, 3'd2, 64'h8000_0000_0000_0000, 63, 0, 4'h4, 64'hFFFF_FFFF_FFFF_FFFF);
        send(1, 3'd4, 64'h1, 1, 0, 4'h5, 64'h8000_0000_0000_0000);
        send(1, 3'd4, 64'h1, 1, 1, 4'h6, 64'hFFFF_FFFF_8000_0000);
        send(1, 3'd2, 64'h0000_0000_8000_0000, 4, 1, 4'h7, 64'hFFFF_FFFF_F800_0000);
        send(1, 3'd1, 64'hFFFF_0000_0000_0000, 64'h44, 0, 4'h8, 64'h0FFF_F000_0000_0000);
        send(1, 3'd3, 64'h8000_0000_0000_0001, 4, 0, 4'h9, 64'h0000_0000_0000_0018);
        send(1, 3'd0, 64'h1, 64'h25, 1, 4'hA, 64'h20);
        send(1, 3'd7, 64'h1234, 1, 0, 4'hB, 64'h0);
        drain();

        send(0, 3'd5, 64'hFFFF_FFFF, 3, 0, 4'h5, 64'h0);
        send(0, 3'd0, 64'h3, 1, 0, 4'h6, 64'h6);
        drain();

        fork
            begin
                for (int i = 0; i < 8; i++) send(0, 3'd0, 64'(i), 64'(i), 0, 4'(i), 64'(32'(i) << i));
            end
            begin
                repeat (3) @(posedge clk);
                #1 a_out_ready = 1'b0;
                repeat (3) @(posedge clk);
                #1 a_out_ready = 1'b1;
            end
        join
        drain();

        a_out_ready = 1'b0;
        send(0, 3'd0, 64'h1, 1, 0, 4'hC, 64'h2);
        send(0, 3'd0, 64'h2, 1, 0, 4'hD, 64'h4);
        reset = 1'b1;
        qa.delete();
        @(posedge clk);
        #1 reset = 1'b0;
        a_out_ready = 1'b1;
        @(negedge clk);
        chk("midrst_out_valid", a_out_valid, 0);
        chk("midrst_out_result", a_out_result, 0);
        chk("midrst_out_tag", a_out_tag, 0);
        chk("midrst_out_illegal", a_out_illegal, 0);
        chk("midrst_in_ready", a_in_ready, 1);
        @(posedge clk);
        #1;
        send(0, 3'd1, 64'hF0, 4, 0, 4'hE, 64'h0F);
        drain();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/shift_unit_pipe.md
# shift_unit_pipe

Parametrised, pipelined barrel shifter with valid/ready handshaking. It extends the single-cycle 32-bit shift unit with:
- configurable datapath width
- configurable pipeline depth
- rotate operations
- RV64-style word (W) operations
- backpressure and an in-order tag passthrough

It sits in the execute stage beside the ALU. The issue logic drives the input side; writeback consumes the output side.

## Interface

Parameters:
- WIDTH, 32, datapath width; legal values are 32 or 64. SHW = log2(WIDTH).
- STAGES, 2, pipeline register stages; legal range 1..SHW.
- TAG_W, 4, width of the opaque tag carried alongside each operation.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high reset.
- in_valid  in  1  input operation is valid.
- in_ready  out  1  unit accepts the operation this cycle.
- in_a  in  WIDTH  operand to shift.
- in_b  in  WIDTH  shift amount; only bits [SHW-1:0] are used, or [4:0] in word mode.
- in_op  in  3  operation: 000 SLL, 001 SRL, 010 SRA, 011 ROL, 100 ROR, 101–111 reserved.
- in_word  in  1  word mode; ignored when WIDTH=32.
- in_tag  in  TAG_W  opaque tag, returned unchanged with the result.
- out_valid  out  1  result is valid.
- out_ready  in  1  consumer accepts the result this cycle.
- out_result  out  WIDTH  shift result.
- out_tag  out  TAG_W  tag of the operation being output.
- out_illegal  out  1  the operation used a reserved in_op.

## Operation

- Transfers: input transfer = in_valid && in_ready; output transfer = out_valid && out_ready.
- Shift amount: SLL/SRL are logical shifts; SRA is an arithmetic shift that replicates the MSB; ROL/ROR are rotates. The amount is taken modulo WIDTH. An amount of 0 returns in_a unchanged.
- Word mode (WIDTH=64 && in_word=1):
  - Operate on in_a[31:0] with shift amount in_b[4:0], as a 32-bit operation.
  - Sign-extend the 32-bit result from bit 31 to 64 bits. This applies to all five ops (SLLW/SRLW/SRAW/ROLW/RORW semantics).
- Reserved in_op: out_result = 0 and out_illegal = 1. The operation still flows through the pipeline, with its tag, like any other.
- Barrel levels: level k shifts by 2^k, for k = 0..SHW-1. Level k is placed in stage floor(k*STAGES/SHW). Stage s ends in pipeline register s. Register STAGES-1 drives out_*.
- Pipeline enable: en = !out_valid || out_ready. All stages advance together when en=1 and hold when en=0. in_ready = en && !reset.
- Valid bits: each stage valid bit loads from the previous stage when en=1. Bubbles advance like any other stage.
- Data and tag registers: these load only when en=1 and the incoming valid bit is 1. Otherwise they keep their value.
- Ordering: results leave in acceptance order. Each operation is output exactly once; none is lost or duplicated.

## Timing

- Reset values: all stage valid bits 0, out_valid 0, out_result 0, out_tag 0, out_illegal 0.
- in_ready is 0 while reset=1 and 1 in the first cycle after reset is released.
- Reset mid-operation: all in-flight operations are discarded. out_valid is 0 in the cycle after the reset edge. No stale result appears after reset is released.
- Latency: an input transfer in cycle c produces out_valid=1 in cycle c+STAGES, provided there is no stall.
- Throughput: one operation per cycle while out_ready=1.
- Stall: while out_valid=1 and out_ready=0:
  - out_result, out_tag and out_illegal are held stable;
  - in_ready=0 (same cycle, combinational from out_ready);
  - no internal stage changes.
- Simultaneous input and output transfer in the same cycle is permitted and is the normal full-throughput case.
- in_ready depends combinationally on out_ready and registered state only. It never depends on in_valid.

## Test plan

- WIDTH=32, STAGES=2, SRA: in_a=0x8000_0010, in_b=4, tag=0x3. Expect out_result=0xF800_0001 and out_tag=0x3, with out_valid two cycles after acceptance.
- WIDTH=32, rotates:
  - ROR in_a=0x0000_00F1, in_b=4 → 0x1000_000F.
  - ROL in_a=0x8000_0001, in_b=0x21 (amount 1) → 0x0000_0003.
  - SLL with in_b=0 → in_a unchanged.
- WIDTH=64, STAGES=3, word mode and boundary amounts:
  - SRLW in_a=0xFFFF_FFFF_8000_0000, in_b=1 → 0x0000_0000_4000_0000.
  - SLLW in_a=1, in_b=31 → 0xFFFF_FFFF_8000_0000.
  - SLL 64-bit, in_a=1, in_b=63 → 0x8000_0000_0000_0000.
  - SRA 64-bit, in_a=0x8000_0000_0000_0000, in_b=63 → all ones.
- Backpressure: issue 8 back-to-back operations with tags 0..7, and hold out_ready=0 for 3 cycles mid-stream. Expect:
  - tags 0..7 output in order, with no gaps or duplicates;
  - out_* stable throughout the stall;
  - in_ready=0 during the stall.
- Reserved op: in_op=101 with tag 0x5 → out_result=0, out_illegal=1, out_tag=0x5. The following legal operation has out_illegal=0.
- Reset mid-stream: with 2 operations in flight, assert reset for 1 cycle. Expect:
  - out_valid=0 and all outputs 0 in the next cycle;
  - in_ready=1 after release;
  - a new SRL of 0xF0 by 4 returns 0x0F with no stale output before it.
